// File: rtl/modn_timer_ctrl_if.sv
// Bundle between the control/register side, the modN counter and the timer sequencer.
// The slave modport is the sequencer's view; master is the view of whatever drives it.
interface modn_timer_ctrl_if #(
  parameter int unsigned PW = 8,
  parameter int unsigned RW = 8
);
  logic          start;
  logic          stop;
  logic          mode_periodic;
  logic [PW-1:0] prescale;
  logic [RW-1:0] repeat_cnt;
  logic          cnt_tc;
  logic          irq_ack;
  logic          cnt_en;
  logic          cnt_rst_n;
  logic          busy;
  logic          done;
  logic          irq;
  logic [RW-1:0] epoch;

  modport master (
    output start, stop, mode_periodic, prescale, repeat_cnt, cnt_tc, irq_ack,
    input  cnt_en, cnt_rst_n, busy, done, irq, epoch
  );

  modport slave (
    input  start, stop, mode_periodic, prescale, repeat_cnt, cnt_tc, irq_ack,
    output cnt_en, cnt_rst_n, busy, done, irq, epoch
  );
endinterface

// File: rtl/modn_timer_ctrl.sv
// Sequencer for a modN counter: prescaled enable, epochs per event, one-shot or periodic,
// registered done pulse and sticky irq.
module modn_timer_ctrl #(
  parameter int unsigned PW = 8,
  parameter int unsigned RW = 8
) (
  input logic               i_clk_50,
  input logic               i_rst,
  modn_timer_ctrl_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StArm  = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]    r_state, w_state_nxt;
  logic [PW-1:0] r_pre_cnt, w_pre_cnt_nxt;
  logic [PW-1:0] r_presc;
  logic [RW-1:0] r_repeat;
  logic          r_mode;
  logic [RW-1:0] r_epoch, w_epoch_nxt;
  logic          r_done, w_done_nxt;
  logic          r_irq, w_irq_nxt;
  logic          w_latch;
  logic          w_cnt_en;
  logic          w_epoch_evt;
  logic [RW-1:0] w_epoch_inc;
  logic          w_final;

  assign w_cnt_en    = (r_state == StRun) && (r_pre_cnt == r_presc);
  assign w_epoch_evt = w_cnt_en && bus.cnt_tc;
  assign w_epoch_inc = r_epoch + RW'(1);
  assign w_final     = w_epoch_evt && (w_epoch_inc == r_repeat);

  always_comb begin
    w_state_nxt   = r_state;
    w_pre_cnt_nxt = r_pre_cnt;
    w_epoch_nxt   = r_epoch;
    w_done_nxt    = 1'b0;
    w_latch       = 1'b0;
    case (r_state)
      StIdle: begin
        w_pre_cnt_nxt = '0;
        if (bus.start && !bus.stop) begin
          w_latch     = 1'b1;
          w_state_nxt = StArm;
        end
      end
      StArm: begin
        w_pre_cnt_nxt = '0;
        w_epoch_nxt   = '0;
        w_state_nxt   = bus.stop ? StIdle : StRun;
      end
      StRun: begin
        w_pre_cnt_nxt = (r_pre_cnt == r_presc) ? '0 : r_pre_cnt + PW'(1);
        // stop discards any epoch event of the same cycle
        if (bus.stop) begin
          w_state_nxt = StIdle;
        end else if (w_final) begin
          w_done_nxt = 1'b1;
          if (r_mode) begin
            w_epoch_nxt = '0;
          end else begin
            w_epoch_nxt = w_epoch_inc;
            w_state_nxt = StDone;
          end
        end else if (w_epoch_evt) begin
          w_epoch_nxt = w_epoch_inc;
        end
      end
      StDone: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // irq set wins over a coincident acknowledge
  assign w_irq_nxt = w_done_nxt | (r_irq & ~(bus.irq_ack & ~r_done));

  always_ff @(posedge i_clk_50 or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_pre_cnt <= '0;
      r_presc   <= '0;
      r_repeat  <= '0;
      r_mode    <= 1'b0;
      r_epoch   <= '0;
      r_done    <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre_cnt <= w_pre_cnt_nxt;
      r_epoch   <= w_epoch_nxt;
      r_done    <= w_done_nxt;
      r_irq     <= w_irq_nxt;
      if (w_latch) begin
        r_presc  <= bus.prescale;
        r_mode   <= bus.mode_periodic;
        r_repeat <= (bus.repeat_cnt == '0) ? RW'(1) : bus.repeat_cnt;
      end
    end
  end

  assign bus.cnt_en    = w_cnt_en;
  assign bus.cnt_rst_n = (r_state == StRun) || (r_state == StDone);
  assign bus.busy      = (r_state == StArm) || (r_state == StRun);
  assign bus.done      = r_done;
  assign bus.irq       = r_irq;
  assign bus.epoch     = r_epoch;

endmodule

// File: doc/modn_timer_ctrl.md
Name: modn_timer_ctrl

Overview:
- Sequencer for the timer0 modN counter. It drives the counter's enable and active-low reset and watches its terminal-count flag.
- Provides a prescaler, a programmable number of counter wraps (epochs) per event, one-shot or periodic mode, a done pulse and a sticky interrupt with acknowledge.
- Sits between the register/control logic and one modN instance (width N, modulus M).

Parameters:
- PW, 8, prescaler width. The counter is enabled once every (prescale+1) clocks.
- RW, 8, repeat-count width (epochs per done event).

Ports:
- clk_50  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  launch request, sampled in IDLE only.
- stop  input  1  abort request, effective in ARM/RUN.
- mode_periodic  input  1  0 = one-shot, 1 = periodic. Latched at start.
- prescale  input  PW  enable divider value. Latched at start.
- repeat_cnt  input  RW  epochs per event; 0 is treated as 1. Latched at start.
- cnt_tc  input  1  modN terminal count. High while the counter holds M-1.
- cnt_en  output  1  drives modN en.
- cnt_rst_n  output  1  drives modN rst_n (active-low clear).
- busy  output  1  high in ARM and RUN.
- done  output  1  one-cycle event pulse.
- irq  output  1  sticky interrupt.
- irq_ack  input  1  clears irq.
- epoch  output  RW  completed epochs in the current event.

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt_en=0, cnt_rst_n=0, busy=0, done=0, irq=0, epoch=0, prescaler=0, latched config=0.
- States: IDLE, ARM, RUN, DONE.
- IDLE:
  - cnt_rst_n=0, so the counter is held cleared; cnt_en=0.
  - start=1 and stop=0 at an edge: latch mode/prescale/repeat (0 becomes 1), go to ARM.
  - start and stop together: stay IDLE.
- ARM (exactly 1 cycle):
  - cnt_rst_n=0, prescaler=0, epoch=0.
  - Go to RUN, or to IDLE if stop=1.
- RUN:
  - cnt_rst_n=1. The prescaler counts 0..presc_q and wraps.
  - cnt_en = (state==RUN) && (pre_cnt==presc_q), combinational from registered state. With prescale=0, cnt_en=1 every RUN cycle.
  - Epoch event: a cycle with cnt_en=1 and cnt_tc=1 (the counter wraps on that edge). epoch increments at the edge.
  - Final epoch (epoch+1 == repeat_q):
    - One-shot: go to DONE.
    - Periodic: epoch becomes 0, stay in RUN, and done=1 in the next cycle. The prescaler and counter keep running with no gap.
  - stop=1: go to IDLE at that edge. No done, no irq, and the epoch event of that cycle is discarded. stop has priority over the final-epoch transition.
  - start is ignored in RUN.
- DONE (1 cycle, one-shot only): cnt_en=0, cnt_rst_n=1, epoch holds repeat_q. Go to IDLE.
- done is registered: high for exactly the one cycle after the final-epoch edge, in both modes.
- irq: set on any cycle where done=1 and held until an edge with irq_ack=1 and done=0. If irq_ack and done coincide, set wins.
- Latency (one-shot): start sampled at edge 0 → ARM in cycle 1 → RUN for (prescale+1)·M·repeat cycles → done high in cycle 2+(prescale+1)·M·repeat.
- Periodic: done period = (prescale+1)·M·repeat cycles.
- Reset during any state: immediate return to reset values, and the counter is cleared via cnt_rst_n=0.
- Config inputs changed while busy have no effect until the next start.

Test Plan:
- M=10, prescale=0, repeat=1, one-shot; start pulse at edge 0 → cnt_rst_n low in cycles 0–1; cnt_en high in cycles 2–11; done=1 only in cycle 12; irq=1 from cycle 12; busy low from cycle 12; back to IDLE in cycle 13.
- prescale=1, repeat=3, one-shot → cnt_en every 2nd RUN cycle; epoch steps 1,2 then 3; done in cycle 62.
- Periodic, prescale=0, repeat=2 → done pulses in cycles 22, 42, 62, … Pulse irq_ack at cycle 30 → irq low at 31, set again at 42. irq_ack in the same cycle as done → irq stays 1.
- stop asserted in RUN on the same cycle as the final epoch event → IDLE next cycle, no done, irq unchanged, cnt_rst_n=0.
- start together with stop in IDLE → remains IDLE. start in RUN → no restart, timing unchanged. repeat_cnt=0 → behaves as 1.
- rst asserted mid-RUN (cycle 7) → all outputs return to reset values asynchronously. After release, a new start reproduces the first scenario's timing exactly.
